// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the CPU MEM stage and a
// DMA/debug requester. Each access takes LATENCY BUSY cycles followed by one
// DONE cycle. The CPU is stalled until its own access completes.
// Build option: define DMEM_ARB_RR_EN for round-robin tie-breaking.
// Without it, the CPU always wins ties.
module dmem_arbiter #(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned ADDR_W  = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_wdata_i,
  output logic [31:0]       cpu_rdata_o,
  output logic              cpu_stall_o,
  input  logic              dma_req_i,
  input  logic              dma_we_i,
  input  logic [31:0]       dma_addr_i,
  input  logic [31:0]       dma_wdata_i,
  output logic [31:0]       dma_rdata_o,
  output logic              dma_ack_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_DMA = 1'b1
  } grant_t;

  state_t             state_q, state_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  grant_t             grant_q, grant_n;
  grant_t             last_q, last_n;
  logic               we_q, we_n;
  logic [ADDR_W-1:0]  addr_q, addr_n;
  logic [31:0]        wdata_q, wdata_n;
  logic [31:0]        cpu_rdata_q, cpu_rdata_n;
  logic [31:0]        dma_rdata_q, dma_rdata_n;
  logic               win_dma;
  logic               final_beat;
  logic               unused_addr_bits;

  // Byte address bits outside the word index are deliberately discarded.
  assign unused_addr_bits = ^{cpu_addr_i, dma_addr_i};

  // Pick the winner among the current requesters.
  always_comb begin
    win_dma = 1'b0;
    if (dma_req_i && !cpu_req_i) begin
      win_dma = 1'b1;
    end else if (dma_req_i && cpu_req_i) begin
`ifdef DMEM_ARB_RR_EN
      win_dma = (last_q == GNT_CPU);
`else
      win_dma = 1'b0;
`endif
    end
  end

  assign final_beat = (state_q == BUSY) && (cnt_q == '0);

  // State and transaction registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      grant_q     <= GNT_CPU;
      last_q      <= GNT_DMA;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      grant_q     <= grant_n;
      last_q      <= last_n;
      we_q        <= we_n;
      addr_q      <= addr_n;
      wdata_q     <= wdata_n;
      cpu_rdata_q <= cpu_rdata_n;
      dma_rdata_q <= dma_rdata_n;
    end
  end

  // Next-state logic: grant in IDLE, count down in BUSY, single DONE cycle.
  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    grant_n     = grant_q;
    last_n      = last_q;
    we_n        = we_q;
    addr_n      = addr_q;
    wdata_n     = wdata_q;
    cpu_rdata_n = cpu_rdata_q;
    dma_rdata_n = dma_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (cpu_req_i || dma_req_i) begin
          state_n = BUSY;
          cnt_n   = CNT_W'(LATENCY - 1);
          if (win_dma) begin
            grant_n = GNT_DMA;
            last_n  = GNT_DMA;
            we_n    = dma_we_i;
            addr_n  = dma_addr_i[ADDR_W+1:2];
            wdata_n = dma_wdata_i;
          end else begin
            grant_n = GNT_CPU;
            last_n  = GNT_CPU;
            we_n    = cpu_we_i;
            addr_n  = cpu_addr_i[ADDR_W+1:2];
            wdata_n = cpu_wdata_i;
          end
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_n = DONE;
          if (!we_q) begin
            if (grant_q == GNT_DMA) begin
              dma_rdata_n = mem_rdata_i;
            end else begin
              cpu_rdata_n = mem_rdata_i;
            end
          end
        end else begin
          cnt_n = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Memory port and requester-facing outputs.
  always_comb begin
    mem_en_o    = (state_q == BUSY);
    mem_we_o    = final_beat && we_q;
    mem_addr_o  = (state_q == BUSY) ? addr_q : '0;
    mem_wdata_o = (state_q == BUSY) ? wdata_q : '0;
    dma_ack_o   = (state_q == DONE) && (grant_q == GNT_DMA);
    cpu_stall_o = cpu_req_i && !((state_q == DONE) && (grant_q == GNT_CPU));
    cpu_rdata_o = cpu_rdata_q;
    dma_rdata_o = dma_rdata_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter (LATENCY=4, ADDR_W=5) with a 32-word memory model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        dma_req = 1'b0, dma_we = 1'b0;
  logic [31:0] dma_addr = '0, dma_wdata = '0;
  logic [31:0] dma_rdata;
  logic        dma_ack;
  logic        mem_en, mem_we;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [31:0] mem [32];

  int n_checks = 0;
  int n_fail   = 0;

  dmem_arbiter #(.LATENCY(4), .ADDR_W(5)) dut (
    .clk_i(clk), .rst_i(rst),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
    .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata), .cpu_stall_o(cpu_stall),
    .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr),
    .dma_wdata_i(dma_wdata), .dma_rdata_o(dma_rdata), .dma_ack_o(dma_ack),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Start of a cycle: just after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Sample point: falling edge of the current cycle.
  task automatic samp();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] <= 32'(i) + 32'h100;
    mem[0] <= 32'd5;
    mem[1] <= 32'd9;
    mem[2] <= 32'h22;
    mem[3] <= 32'h0;

    // Reset state
    cpu_req = 1'b1;
    #2;
    chk("rst_stall_follows_req", {31'b0, cpu_stall}, 32'd1);
    chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
    chk("rst_mem_addr", {27'b0, mem_addr}, 32'd0);
    chk("rst_dma_ack", {31'b0, dma_ack}, 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_dma_rdata", dma_rdata, 32'd0);
    cpu_req = 1'b0;
    #1;
    chk("rst_stall_no_req", {31'b0, cpu_stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // CPU read of word 0
    cyc();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h00;
    samp();
    chk("rd_c0_stall", {31'b0, cpu_stall}, 32'd1);
    chk("rd_c0_en", {31'b0, mem_en}, 32'd0);
    for (int c = 1; c <= 4; c++) begin
      cyc(); samp();
      chk($sformatf("rd_c%0d_en", c), {31'b0, mem_en}, 32'd1);
      chk($sformatf("rd_c%0d_stall", c), {31'b0, cpu_stall}, 32'd1);
      chk($sformatf("rd_c%0d_we", c), {31'b0, mem_we}, 32'd0);
    end
    cyc(); samp();
    chk("rd_c5_stall", {31'b0, cpu_stall}, 32'd0);
    chk("rd_c5_rdata", cpu_rdata, 32'd5);
    chk("rd_c5_en", {31'b0, mem_en}, 32'd0);
    cyc();
    cpu_req = 1'b0;

    // DMA write 0xDEADBEEF to 0x0C
    cyc();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h0C; dma_wdata = 32'hDEADBEEF;
    samp();
    chk("dw_c0_ack", {31'b0, dma_ack}, 32'd0);
    for (int c = 1; c <= 4; c++) begin
      cyc(); samp();
      chk($sformatf("dw_c%0d_we", c), {31'b0, mem_we}, (c == 4) ? 32'd1 : 32'd0);
      chk($sformatf("dw_c%0d_addr", c), {27'b0, mem_addr}, 32'd3);
      chk($sformatf("dw_c%0d_ack", c), {31'b0, dma_ack}, 32'd0);
    end
    cyc(); samp();
    chk("dw_c5_ack", {31'b0, dma_ack}, 32'd1);
    chk("dw_c5_we", {31'b0, mem_we}, 32'd0);
    chk("dw_mem3", mem[3], 32'hDEADBEEF);
    chk("dw_rdata_kept", dma_rdata, 32'd0);
    cyc();
    dma_req = 1'b0; dma_we = 1'b0;
    samp();
    chk("dw_c6_ack", {31'b0, dma_ack}, 32'd0);

    // Tie: CPU reads 0x04, DMA reads 0x08, both held; CPU re-requests 0x00 at cycle 6
    cyc();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h04;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h08;
    samp();
    for (int c = 1; c <= 4; c++) begin
      cyc(); samp();
      chk($sformatf("tie_c%0d_addr", c), {27'b0, mem_addr}, 32'd1);
    end
    cyc(); samp();
    chk("tie_c5_stall", {31'b0, cpu_stall}, 32'd0);
    chk("tie_c5_rdata", cpu_rdata, 32'd9);
    chk("tie_c5_ack", {31'b0, dma_ack}, 32'd0);
    cyc();
    cpu_addr = 32'h00;
    samp();
    chk("tie_c6_stall", {31'b0, cpu_stall}, 32'd1);
    for (int c = 7; c <= 17; c++) begin
      cyc();
`ifdef DMEM_ARB_RR_EN
      if (c == 12) dma_req = 1'b0;
`else
      if (c == 12) cpu_req = 1'b0;
`endif
      samp();
`ifdef DMEM_ARB_RR_EN
      if (c <= 10) chk($sformatf("rr_c%0d_addr", c), {27'b0, mem_addr}, 32'd2);
      chk($sformatf("rr_c%0d_ack", c), {31'b0, dma_ack}, (c == 11) ? 32'd1 : 32'd0);
      chk($sformatf("rr_c%0d_stall", c), {31'b0, cpu_stall}, (c == 17) ? 32'd0 : 32'd1);
      if (c == 11) chk("rr_c11_drdata", dma_rdata, 32'h22);
      if (c == 17) chk("rr_c17_rdata", cpu_rdata, 32'd5);
`else
      if (c <= 10) chk($sformatf("fp_c%0d_addr", c), {27'b0, mem_addr}, 32'd0);
      if (c >= 13 && c <= 16) chk($sformatf("fp_c%0d_addr", c), {27'b0, mem_addr}, 32'd2);
      chk($sformatf("fp_c%0d_ack", c), {31'b0, dma_ack}, (c == 17) ? 32'd1 : 32'd0);
      if (c <= 11) chk($sformatf("fp_c%0d_stall", c), {31'b0, cpu_stall}, (c == 11) ? 32'd0 : 32'd1);
      if (c == 11) chk("fp_c11_rdata", cpu_rdata, 32'd5);
      if (c == 17) chk("fp_c17_drdata", dma_rdata, 32'h22);
`endif
    end
    cyc();
    cpu_req = 1'b0; dma_req = 1'b0;

    // Reset in the middle of a CPU store of 7 to 0x04
    cyc();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h04; cpu_wdata = 32'd7;
    samp();
    cyc(); samp();
    chk("rw_c1_en", {31'b0, mem_en}, 32'd1);
    cyc();
    rst = 1'b1;
    #1;
    chk("rw_rst_en", {31'b0, mem_en}, 32'd0);
    chk("rw_rst_we", {31'b0, mem_we}, 32'd0);
    chk("rw_rst_stall", {31'b0, cpu_stall}, 32'd1);
    chk("rw_rst_rdata", cpu_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("rw_mem1_kept", mem[1], 32'd9);
    for (int c = 3; c <= 6; c++) begin
      cyc(); samp();
      chk($sformatf("rw_c%0d_stall", c), {31'b0, cpu_stall}, 32'd1);
      chk($sformatf("rw_c%0d_en", c), {31'b0, mem_en}, 32'd1);
    end
    cyc(); samp();
    chk("rw_c7_stall", {31'b0, cpu_stall}, 32'd0);
    chk("rw_mem1", mem[1], 32'd7);
    chk("rw_rdata_kept", cpu_rdata, 32'd0);
    cyc();
    cpu_req = 1'b0; cpu_we = 1'b0;

    // Back-to-back CPU reads of 0x00 then 0x04
    cyc();
    cpu_req = 1'b1; cpu_addr = 32'h00;
    for (int c = 1; c <= 11; c++) begin
      cyc();
      if (c == 6) cpu_addr = 32'h04;
      samp();
      chk($sformatf("bb_c%0d_stall", c), {31'b0, cpu_stall},
          (c == 5 || c == 11) ? 32'd0 : 32'd1);
      if (c == 5)  chk("bb_c5_rdata", cpu_rdata, 32'd5);
      if (c == 11) chk("bb_c11_rdata", cpu_rdata, 32'd7);
    end
    cyc();
    cpu_req = 1'b0;

    // Address mapping: 0x0E -> word 3, 0x80 -> word 0 (wraps)
    cyc();
    cpu_req = 1'b1; cpu_addr = 32'h0E;
    cyc(); samp();
    chk("map_0e", {27'b0, mem_addr}, 32'd3);
    for (int c = 2; c <= 5; c++) cyc();
    samp();
    chk("map_0e_rdata", cpu_rdata, 32'hDEADBEEF);
    cyc();
    cpu_addr = 32'h80;
    cyc(); samp();
    chk("map_80", {27'b0, mem_addr}, 32'd0);
    for (int c = 2; c <= 5; c++) cyc();
    samp();
    chk("map_80_rdata", cpu_rdata, 32'd5);
    chk("map_80_stall", {31'b0, cpu_stall}, 32'd0);
    cyc();
    cpu_req = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
